mips_main_ctrl: RTL and testbench
=================================

Name: mips_main_ctrl

Overview:
- Moore main-control FSM of the multicycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback for each instruction and drives all datapath enables and muxes.
- Produces the 2-bit ALU operation class consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode by funct.
- op and funct come from the instruction register, which is stable from DECODE until the next FETCH.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-if-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode
FN_JR, 6'h08, R-type funct code for jump-register

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
op  input  6  instruction[31:26]
func  input  6  instruction[5:0]
zero  input  1  ALU zero flag, combinational from the current ALU result
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register load enable
RegDst  output  1  write register select: 0 = rt, 1 = rd
MemtoReg  output  1  writeback data select: 0 = ALUOut, 1 = MDR
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register
ALUSrcB  output  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  output  2  operation class to the ALU control decoder
PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
PCEn  output  1  PC load enable
illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
state  output  4  current state, for debug

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1, state <= FETCH (0).
  - While rst=1, MemWrite, IRWrite, RegWrite, PCEn and illegal_op are forced to 0.
  - All other outputs follow the FETCH decode.
  - A reset asserted mid-instruction abandons that instruction. No partial writeback occurs after the reset edge.
- Output style:
  - All outputs are a combinational function of state only, except PCEn and illegal_op.
  - Any output not listed for a state is 0.
- PCEn = PCWrite | (Branch & zero). PCWrite and Branch are internal state decodes.
- States (encoding, asserted outputs -> next state):
  - 0 FETCH: IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00 -> DECODE
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op:
    - LW or SW -> MEMADR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other op -> FETCH, with illegal_op=1 for this cycle
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if op=LW, MEMWRITE if op=SW
  - 3 MEMREAD: IorD=1 -> MEMWB
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite -> FETCH
  - 5 MEMWRITE: IorD=1, MemWrite -> FETCH
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> JR if func=FN_JR, else ALUWB
  - 7 ALUWB: RegDst=1, MemtoReg=0, RegWrite -> FETCH
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch -> FETCH
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB
  - 10 ADDIWB: RegDst=0, MemtoReg=0, RegWrite -> FETCH
  - 11 JUMP: PCSrc=10, PCWrite -> FETCH
  - 12 JR: PCSrc=01, PCWrite -> FETCH. ALUOut holds rs+$0 from EXECUTE.
  - 13–15 (unreachable): all enables 0 -> FETCH on the next edge.
- Latency in cycles, FETCH through the last state:
  - LW 5
  - SW 4, R-type 4, JR 4, ADDI 4
  - BEQ 3, J 3
- Side effects of the R-type path:
  - JR passes through EXECUTE with ALUOp=10. The downstream decoder maps funct 0x08 to add.
  - JR never asserts RegWrite.
- op and func are only sampled in DECODE, MEMADR and EXECUTE. Changes to them in other states have no effect.

Optional Feature:
- Macro: MIPS_BNE_EN.
- Defined:
  - op=6'h05 in DECODE -> BRANCH, instead of illegal.
  - A bne flag is latched in DECODE and cleared in FETCH.
  - In BRANCH, PCEn = Branch & (zero ^ bne).
  - BNE latency is 3 cycles.
- Undefined: op=6'h05 is illegal (pulses illegal_op, returns to FETCH), and PCEn = PCWrite | (Branch & zero).

Test Plan:
- Reset then LW:
  - Stimulus: rst=1 for 2 cycles, then rst=0; op=6'h23.
  - Required: during reset IRWrite=0 and PCEn=0. After release, states 0,1,2,3,4,0. MEMWB shows RegWrite=1, MemtoReg=1, RegDst=0. MEMADR shows ALUSrcB=10, ALUOp=00.
- R-type add:
  - Stimulus: op=0, func=6'h20.
  - Required: states 0,1,6,7,0. EXECUTE shows ALUOp=10, ALUSrcA=1, ALUSrcB=00. ALUWB shows RegDst=1, RegWrite=1.
- JR:
  - Stimulus: op=0, func=6'h08.
  - Required: states 0,1,6,12,0. In state 12, PCEn=1 and PCSrc=01. RegWrite stays 0 throughout.
- BEQ:
  - Stimulus: op=6'h04, once with zero=1 and once with zero=0 in BRANCH.
  - Required: PCEn is 1 and 0 respectively in state 8. ALUOp=01 and PCSrc=01. Next state is FETCH.
- Illegal opcode:
  - Stimulus: op=6'h3F.
  - Required: illegal_op=1 for exactly the DECODE cycle, then FETCH. With MIPS_BNE_EN, op=6'h05 with zero=0 gives PCEn=1 in BRANCH.
- Reset mid-SW:
  - Stimulus: op=6'h2B; assert rst in MEMADR.
  - Required: next state is FETCH and MemWrite is never asserted.

Source files
------------

// File: rtl/mips_main_ctrl_if.sv
// Control bundle between the multicycle MIPS main-control FSM and the datapath.
// master: controller side (takes op/func/zero, drives enables and muxes); slave: datapath side.
interface mips_main_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op,
    input  func,
    input  zero,
    output IorD,
    output MemWrite,
    output IRWrite,
    output RegDst,
    output MemtoReg,
    output RegWrite,
    output ALUSrcA,
    output ALUSrcB,
    output ALUOp,
    output PCSrc,
    output PCEn,
    output illegal_op,
    output state
  );

  modport slave (
    output op,
    output func,
    output zero,
    input  IorD,
    input  MemWrite,
    input  IRWrite,
    input  RegDst,
    input  MemtoReg,
    input  RegWrite,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ALUOp,
    input  PCSrc,
    input  PCEn,
    input  illegal_op,
    input  state
  );
endinterface

// File: rtl/mips_main_ctrl.sv
// Moore main-control FSM of the multicycle MIPS datapath (fetch..writeback sequencing).
// Ports: clk, rst (sync, active-high), bus (mips_main_ctrl_if.master).
// Optional: define MIPS_BNE_EN to decode op 6'h05 as bne through the BRANCH state.
module mips_main_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] FN_JR    = 6'h08
) (
  input logic             clk,
  input logic             rst,
  mips_main_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       illegal;
  logic       taken;

`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE = 6'h05;

  logic bne_q;
  logic bne_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      bne_q <= 1'b0;
    end else begin
      bne_q <= bne_d;
    end
  end

  // bne reuses the beq datapath; only the sense of zero flips
  assign taken = bus.zero ^ bne_q;
`else
  assign taken = bus.zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
`ifdef MIPS_BNE_EN
    bne_d      = bne_q;
`endif
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
`ifdef MIPS_BNE_EN
        bne_d     = 1'b0;
`endif
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
`ifdef MIPS_BNE_EN
        bne_d     = (bus.op == OP_BNE);
`endif
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):    state_d = S_MEMADR;
          (bus.op == OP_RTYPE): state_d = S_EXECUTE;
          (bus.op == OP_BEQ):   state_d = S_BRANCH;
          (bus.op == OP_ADDI):  state_d = S_ADDIEX;
          (bus.op == OP_J):     state_d = S_JUMP;
`ifdef MIPS_BNE_EN
          (bus.op == OP_BNE):   state_d = S_BRANCH;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (bus.op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        // jr still flows through the R-type ALU path so ALUOut = rs + $0
        state_d   = (bus.func == FN_JR) ? S_JR : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pc_src   = 2'b01;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // write strobes are held off during reset so an abandoned
  // instruction cannot touch architectural state
  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write & ~rst;
  assign bus.IRWrite    = ir_write & ~rst;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write & ~rst;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.PCSrc      = pc_src;
  assign bus.PCEn       = ~rst & (pc_write | (branch & taken));
  assign bus.illegal_op = illegal & ~rst;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Directed testbench for mips_main_ctrl.
// Walks each instruction class through the FSM and checks states and controls.
module tb_mips_main_ctrl;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  mips_main_ctrl_if bus ();

  mips_main_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    rst = 1'b1;
    bus.op = 6'h23;
    bus.func = 6'h00;
    bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (bus.state !== 4'd0 || bus.IRWrite !== 1'b0 || bus.PCEn !== 1'b0) begin
        nerr++;
        $display("FAIL reset: state=%0d IRWrite=%b PCEn=%b want 0/0/0",
                 bus.state, bus.IRWrite, bus.PCEn);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0]) begin
        nerr++;
        $display("FAIL lw_seq[%0d]: state=%0d want %0d", i, bus.state, exp_st[i]);
      end
      if (i == 0) begin
        nvec++;
        if (bus.IRWrite !== 1'b1 || bus.PCEn !== 1'b1) begin
          nerr++;
          $display("FAIL fetch: IRWrite=%b PCEn=%b want 1/1", bus.IRWrite, bus.PCEn);
        end
      end
      if (i == 2) begin
        nvec++;
        if (bus.ALUSrcB !== 2'b10 || bus.ALUOp !== 2'b00 || bus.ALUSrcA !== 1'b1) begin
          nerr++;
          $display("FAIL lw_memadr: ALUSrcB=%b ALUOp=%b ALUSrcA=%b want 10/00/1",
                   bus.ALUSrcB, bus.ALUOp, bus.ALUSrcA);
        end
      end
      if (i == 3) begin
        nvec++;
        if (bus.IorD !== 1'b1 || bus.MemWrite !== 1'b0) begin
          nerr++;
          $display("FAIL lw_memread: IorD=%b MemWrite=%b want 1/0", bus.IorD, bus.MemWrite);
        end
      end
      if (i == 4) begin
        nvec++;
        if (bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b1 || bus.RegDst !== 1'b0) begin
          nerr++;
          $display("FAIL lw_memwb: RegWrite=%b MemtoReg=%b RegDst=%b want 1/1/0",
                   bus.RegWrite, bus.MemtoReg, bus.RegDst);
        end
      end
    end
  endtask

  task automatic test_sw();
    int exp_st[5] = '{0, 1, 2, 5, 0};
    bus.op = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0]) begin
        nerr++;
        $display("FAIL sw_seq[%0d]: state=%0d want %0d", i, bus.state, exp_st[i]);
      end
      nvec++;
      if (bus.MemWrite !== (i == 3)) begin
        nerr++;
        $display("FAIL sw_memwrite[%0d]: MemWrite=%b want %b", i, bus.MemWrite, (i == 3));
      end
    end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    bus.op = 6'h00;
    bus.func = 6'h20;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0]) begin
        nerr++;
        $display("FAIL rtype_seq[%0d]: state=%0d want %0d", i, bus.state, exp_st[i]);
      end
      if (i == 2) begin
        nvec++;
        if (bus.ALUOp !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin
          nerr++;
          $display("FAIL rtype_exec: ALUOp=%b ALUSrcA=%b ALUSrcB=%b want 10/1/00",
                   bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB);
        end
      end
      if (i == 3) begin
        nvec++;
        if (bus.RegDst !== 1'b1 || bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b0) begin
          nerr++;
          $display("FAIL rtype_wb: RegDst=%b RegWrite=%b MemtoReg=%b want 1/1/0",
                   bus.RegDst, bus.RegWrite, bus.MemtoReg);
        end
        // op is not sampled in ALUWB; garbage here must not matter
        bus.op = 6'h3F;
      end
    end
  endtask

  task automatic test_jr();
    int exp_st[5] = '{0, 1, 6, 12, 0};
    bus.op = 6'h00;
    bus.func = 6'h08;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0]) begin
        nerr++;
        $display("FAIL jr_seq[%0d]: state=%0d want %0d", i, bus.state, exp_st[i]);
      end
      nvec++;
      if (bus.RegWrite !== 1'b0) begin
        nerr++;
        $display("FAIL jr_regwrite[%0d]: RegWrite=%b want 0", i, bus.RegWrite);
      end
      if (i == 3) begin
        nvec++;
        if (bus.PCEn !== 1'b1 || bus.PCSrc !== 2'b01) begin
          nerr++;
          $display("FAIL jr_pc: PCEn=%b PCSrc=%b want 1/01", bus.PCEn, bus.PCSrc);
        end
      end
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_en,
                             input string nm);
    int exp_st[4] = '{0, 1, 8, 0};
    bus.op = op;
    bus.zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (i == 2) begin
        bus.zero = z;
        #1;
      end
      nvec++;
      if (bus.state !== exp_st[i][3:0]) begin
        nerr++;
        $display("FAIL %s_seq[%0d]: state=%0d want %0d", nm, i, bus.state, exp_st[i]);
      end
      if (i == 2) begin
        nvec++;
        if (bus.PCEn !== exp_en || bus.ALUOp !== 2'b01 || bus.PCSrc !== 2'b01) begin
          nerr++;
          $display("FAIL %s_br: PCEn=%b ALUOp=%b PCSrc=%b want %b/01/01",
                   nm, bus.PCEn, bus.ALUOp, bus.PCSrc, exp_en);
        end
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_illegal(input logic [5:0] op, input string nm);
    int exp_st[3] = '{0, 1, 0};
    bus.op = op;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0] || bus.illegal_op !== (i == 1)) begin
        nerr++;
        $display("FAIL %s[%0d]: state=%0d illegal_op=%b want %0d/%b",
                 nm, i, bus.state, bus.illegal_op, exp_st[i], (i == 1));
      end
    end
  endtask

  task automatic test_addi_j();
    int exp_a[5] = '{0, 1, 9, 10, 0};
    int exp_j[4] = '{0, 1, 11, 0};
    bus.op = 6'h08;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_a[i][3:0]) begin
        nerr++;
        $display("FAIL addi_seq[%0d]: state=%0d want %0d", i, bus.state, exp_a[i]);
      end
      if (i == 3) begin
        nvec++;
        if (bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 || bus.MemtoReg !== 1'b0) begin
          nerr++;
          $display("FAIL addi_wb: RegWrite=%b RegDst=%b MemtoReg=%b want 1/0/0",
                   bus.RegWrite, bus.RegDst, bus.MemtoReg);
        end
      end
    end
    bus.op = 6'h02;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_j[i][3:0]) begin
        nerr++;
        $display("FAIL j_seq[%0d]: state=%0d want %0d", i, bus.state, exp_j[i]);
      end
      if (i == 2) begin
        nvec++;
        if (bus.PCEn !== 1'b1 || bus.PCSrc !== 2'b10) begin
          nerr++;
          $display("FAIL j_pc: PCEn=%b PCSrc=%b want 1/10", bus.PCEn, bus.PCSrc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    int exp_st[3] = '{0, 1, 2};
    bus.op = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.state !== exp_st[i][3:0] || bus.MemWrite !== 1'b0) begin
        nerr++;
        $display("FAIL sw_rst_pre[%0d]: state=%0d MemWrite=%b want %0d/0",
                 i, bus.state, bus.MemWrite, exp_st[i]);
      end
    end
    rst = 1'b1;
    tick();
    nvec++;
    if (bus.state !== 4'd0 || bus.MemWrite !== 1'b0) begin
      nerr++;
      $display("FAIL sw_rst: state=%0d MemWrite=%b want 0/0", bus.state, bus.MemWrite);
    end
    bus.op = 6'h00;
    bus.func = 6'h20;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      nvec++;
      if (bus.MemWrite !== 1'b0) begin
        nerr++;
        $display("FAIL sw_rst_post[%0d]: MemWrite=%b want 0", i, bus.MemWrite);
      end
    end
    tick();
    nvec++;
    if (bus.state !== 4'd0) begin
      nerr++;
      $display("FAIL sw_rst_end: state=%0d want 0", bus.state);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.op = 6'h00;
    bus.func = 6'h00;
    bus.zero = 1'b0;
    test_reset_lw();
    test_sw();
    test_rtype();
    test_jr();
    test_branch(6'h04, 1'b1, 1'b1, "beq_t");
    test_branch(6'h04, 1'b0, 1'b0, "beq_nt");
    test_illegal(6'h3F, "illegal");
`ifdef MIPS_BNE_EN
    test_branch(6'h05, 1'b0, 1'b1, "bne_t");
    test_branch(6'h05, 1'b1, 1'b0, "bne_nt");
`else
    test_illegal(6'h05, "bne_illegal");
`endif
    test_addi_j();
    test_reset_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
